// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream_demux block.
//   DEMUX_FIFO_DEPTH : entries per output channel FIFO
//   CH0 / CH1        : encoding of the per-beat select
//   OCC_W            : width of a per-channel occupancy value (0..2)
package stream_demux_pkg;

  localparam int DEMUX_FIFO_DEPTH = 2;
  localparam int OCC_W            = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_ONE   = 2'd1;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

  // True when a FIFO with this occupancy cannot take another beat.
  function automatic logic occ_is_full(input logic [OCC_W-1:0] occ);
    return (occ == OCC_FULL);
  endfunction

endpackage

// File: rtl/stream_demux_chan_fifo.sv
// demux_chan_fifo: one output lane of stream_demux.
// A 2-entry first-word-fall-through FIFO built as a head/tail register pair,
// with a valid/ready pop port and a wrapping delivered-beat counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push, i_data    write strobe and beat from the steering logic
//   o_full            occupancy == 2 (registered, no path from i_ready)
//   o_data, o_valid   head entry and "not empty"
//   i_ready           consumer accepts the head this cycle
//   o_count           beats popped so far, wraps at 2^CNT_W
module demux_chan_fifo
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_count
);

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_next;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH-1:0] w_tail_next;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push_ok;

  assign o_full  = occ_is_full(r_occ);
  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_data  = r_head;
  assign o_count = r_count;

  assign w_pop     = o_valid && i_ready;
  // A full FIFO is never refilled in the same cycle it pops.
  assign w_push_ok = i_push && !o_full;

  // The head register is the output itself, so it only changes when a new
  // beat must become visible; after the last pop it keeps its old value.
  always_comb begin
    w_occ_next  = r_occ;
    w_head_next = r_head;
    w_tail_next = r_tail;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_push_ok) begin
          w_head_next = i_data;
          w_occ_next  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_push_ok && w_pop) begin
          w_head_next = i_data;
        end else if (w_push_ok) begin
          w_tail_next = i_data;
          w_occ_next  = OCC_FULL;
        end else if (w_pop) begin
          w_occ_next  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_pop) begin
          w_head_next = r_tail;
          w_occ_next  = OCC_ONE;
        end
      end
      default: begin
        // Encoding 3 is unreachable; fall back to empty rather than hold it.
        w_occ_next = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= OCC_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_occ  <= w_occ_next;
      r_head <= w_head_next;
      r_tail <= w_tail_next;
      if (w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 stream demultiplexer.
// Each accepted input beat is steered by sel into the FIFO of channel 0 or 1;
// every channel has its own 2-deep buffer, valid/ready output and counter.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   data_in, sel, in_valid         input beat, destination channel, present
//   in_ready                       selected channel has room (and not in reset)
//   data_out0/out_valid0/out_ready0  channel 0 stream
//   data_out1/out_valid1/out_ready1  channel 1 stream
//   count0, count1                 beats delivered per channel
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out0,
  output logic             out_valid0,
  input  logic             out_ready0,
  output logic [WIDTH-1:0] data_out1,
  output logic             out_valid1,
  input  logic             out_ready1,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  logic [1:0]       w_push;
  logic [1:0]       w_full;
  logic [1:0]       w_valid;
  logic [1:0]       w_ready;
  logic [WIDTH-1:0] w_dout [2];
  logic [CNT_W-1:0] w_cnt  [2];
  logic             w_accept;

  assign w_ready = {out_ready1, out_ready0};

  // Only registered occupancy and sel feed in_ready, never out_ready*.
  assign in_ready = !rst && !w_full[sel];
  assign w_accept = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      // The unselected channel never sees a write strobe.
      assign w_push[gi] = w_accept && (sel == ((gi == 1) ? CH1 : CH0));

      demux_chan_fifo #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[gi]),
        .i_data  (data_in),
        .o_full  (w_full[gi]),
        .o_data  (w_dout[gi]),
        .o_valid (w_valid[gi]),
        .i_ready (w_ready[gi]),
        .o_count (w_cnt[gi])
      );
    end
  endgenerate

  assign data_out0  = w_dout[0];
  assign data_out1  = w_dout[1];
  assign out_valid0 = w_valid[0];
  assign out_valid1 = w_valid[1];
  assign count0     = w_cnt[0];
  assign count1     = w_cnt[1];

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux (WIDTH=8, CNT_W=4 so counter wrap is cheap).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_stream_demux;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out0;
  logic             out_valid0;
  logic             out_ready0;
  logic [WIDTH-1:0] data_out1;
  logic             out_valid1;
  logic             out_ready1;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out0  (data_out0),
    .out_valid0 (out_valid0),
    .out_ready0 (out_ready0),
    .data_out1  (data_out1),
    .out_valid1 (out_valid1),
    .out_ready1 (out_ready1),
    .count0     (count0),
    .count1     (count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    sel        = 1'b0;
    data_in    = 8'hAA;
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;

    // Reset held two cycles with a beat offered.
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_valid1", out_valid1, 0);
    chk("rst_data0", data_out0, 0);
    chk("rst_data1", data_out1, 0);
    chk("rst_count0", count0, 0);
    chk("rst_count1", count1, 0);
    $display("txn reset done");

    // Basic steering: 15 -> ch0, then 5 -> ch1.
    rst        = 1'b0;
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    in_valid   = 1'b1;
    sel        = 1'b0;
    data_in    = 8'd15;
    #1;
    chk("steer_ready0", in_ready, 1);
    step();
    chk("steer_valid0", out_valid0, 1);
    chk("steer_data0", data_out0, 15);
    chk("steer_valid1_idle", out_valid1, 0);
    sel     = 1'b1;
    data_in = 8'd5;
    #1;
    chk("steer_ready1", in_ready, 1);
    step();
    chk("steer_pop0_valid", out_valid0, 0);
    chk("steer_pop0_hold", data_out0, 15);
    chk("steer_count0", count0, 1);
    chk("steer_valid1", out_valid1, 1);
    chk("steer_data1", data_out1, 5);
    in_valid = 1'b0;
    step();
    chk("steer_count1", count1, 1);
    chk("steer_pop1_valid", out_valid1, 0);
    $display("txn steering done");

    // Backpressure: 3, 4 fill ch0; 9 is refused.
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    in_valid   = 1'b1;
    sel        = 1'b0;
    data_in    = 8'd3;
    #1;
    chk("bp_ready_a", in_ready, 1);
    step();
    data_in = 8'd4;
    #1;
    chk("bp_ready_b", in_ready, 1);
    step();
    data_in = 8'd9;
    #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head", data_out0, 3);
    step();
    chk("bp_stall_valid", out_valid0, 1);
    chk("bp_stall_head", data_out0, 3);
    chk("bp_stall_count", count0, 1);
    $display("txn backpressure done");

    // Independent channels: ch0 full and stalled, 7 -> ch1 still accepted.
    sel     = 1'b1;
    data_in = 8'd7;
    #1;
    chk("ind_ready1", in_ready, 1);
    step();
    chk("ind_valid1", out_valid1, 1);
    chk("ind_data1", data_out1, 7);
    chk("ind_ch0_head", data_out0, 3);
    chk("ind_ch0_valid", out_valid0, 1);
    $display("txn independent done");

    // Drain ch0 while offering 9: no refill while full, then 3,4,9 in order.
    sel        = 1'b0;
    data_in    = 8'd9;
    out_ready0 = 1'b1;
    #1;
    chk("drain_full_ready", in_ready, 0);
    step();
    chk("drain_head4", data_out0, 4);
    chk("drain_count_a", count0, 2);
    chk("drain_ready_now", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("drain_head9", data_out0, 9);
    chk("drain_valid9", out_valid0, 1);
    chk("drain_count_b", count0, 3);
    step();
    chk("drain_empty", out_valid0, 0);
    chk("drain_hold", data_out0, 9);
    chk("drain_count_c", count0, 4);
    $display("txn drain done");

    // Push/pop same cycle at occupancy 1.
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    data_in    = 8'd10;
    step();
    chk("pp_head10", data_out0, 10);
    out_ready0 = 1'b1;
    data_in    = 8'd11;
    #1;
    chk("pp_ready", in_ready, 1);
    step();
    chk("pp_head11", data_out0, 11);
    chk("pp_valid", out_valid0, 1);
    chk("pp_count", count0, 5);
    // Occupancy must still be 1: one more beat fits, the next does not.
    out_ready0 = 1'b0;
    data_in    = 8'd12;
    #1;
    chk("pp_occ1_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("pp_occ2_ready", in_ready, 0);
    chk("pp_occ2_head", data_out0, 11);
    out_ready0 = 1'b1;
    step();
    chk("pp_drain_head12", data_out0, 12);
    step();
    chk("pp_drain_empty", out_valid0, 0);
    chk("pp_drain_count", count0, 7);
    $display("txn push_pop done");

    // Counter wrap on ch1: 7 already queued plus 15 more -> 17 deliveries total.
    out_ready1 = 1'b1;
    step();
    chk("wrap_count_2", count1, 2);
    in_valid = 1'b1;
    sel      = 1'b1;
    for (int i = 0; i < 15; i++) begin
      data_in = 8'(100 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_count1", count1, 1);
    chk("wrap_last_data", data_out1, 114);
    chk("wrap_empty", out_valid1, 0);
    $display("txn wrap done");

    // Reset mid-stream with two beats buffered on ch0.
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    sel        = 1'b0;
    data_in    = 8'd21;
    step();
    data_in = 8'd22;
    step();
    in_valid = 1'b0;
    chk("mid_full_ready", in_ready, 0);
    chk("mid_valid0", out_valid0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    step();
    chk("mid_valid0_clr", out_valid0, 0);
    chk("mid_valid1_clr", out_valid1, 0);
    chk("mid_data0_clr", data_out0, 0);
    chk("mid_count0_clr", count0, 0);
    chk("mid_count1_clr", count1, 0);
    rst = 1'b0;
    #1;
    chk("mid_ready_after", in_ready, 1);
    $display("txn mid_reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-2 stream demultiplexer: the inverse of the two-input data mux.
- Takes one input stream and a per-beat select, and steers each beat to output channel 0 or 1.
- Each channel has its own 2-entry FIFO and a valid/ready handshake, so one stalled channel does not lose data.
- Sits between a shared sensor/command bus and two lane-controller consumers; keeps per-channel delivered-beat counters for status.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- CNT_W, 16, width of per-channel delivered-beat counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  input beat.
- sel  input  1  destination of the current input beat: 0 -> channel 0, 1 -> channel 1.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- data_out0  output  WIDTH  channel 0 head data.
- out_valid0  output  1  channel 0 head valid.
- out_ready0  input  1  channel 0 consumer accepts.
- data_out1  output  WIDTH  channel 1 head data.
- out_valid1  output  1  channel 1 head valid.
- out_ready1  input  1  channel 1 consumer accepts.
- count0  output  CNT_W  beats delivered on channel 0.
- count1  output  CNT_W  beats delivered on channel 1.

Behaviour:
- Reset: rst is sampled on clk only.
  - While rst=1: in_ready=0.
  - On the edge with rst=1: FIFO occupancies cleared; out_valid0/1=0; data_out0/1=0; count0/1=0.
  - Reset mid-operation discards all buffered beats; no partial state survives.
- Push:
  - in_ready = !rst && occupancy(sel channel) < 2.
  - in_ready depends only on registered occupancy and sel, with no path from out_ready*.
  - Accept = in_valid && in_ready; the beat is written into the FIFO of channel sel.
  - The unselected channel is never written.
- Pop: channel k pops when out_valid_k && out_ready_k.
  - count_k increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Latency: a beat accepted at edge N appears on data_out_sel with out_valid_sel=1 after edge N, i.e. one cycle.
  - No combinational pass-through from data_in to data_out.
- FIFO per channel (depth 2, first-word fall-through from register):
  - data_out_k = head entry; out_valid_k = occupancy_k != 0.
  - data_out_k holds its last value when empty.
  - Order within a channel is preserved.
- Simultaneous push and pop, same channel:
  - Occupancy 1: occupancy stays 1; the new beat becomes head after the pop.
  - Occupancy 2 (full): in_ready=0, so the pop alone occurs. No same-cycle refill of a full FIFO.
- Simultaneous pop on both channels is independent; both counters update in the same cycle.
- in_valid=0: sel and data_in are ignored. in_ready is still driven from sel.
- out_valid_k, once high, stays high with data_out_k stable until popped (standard valid/ready rule).
- Per-channel occupancy encoding: 0, 1, 2. Values other than 0..2 are unreachable; the implementation must not create them.

Decomposition:
- Shared package/header holds:
  - DEMUX_FIFO_DEPTH = 2.
  - Channel encoding CH0 = 1'b0, CH1 = 1'b1.
  - Occupancy width constant = 2.
- One natural sub-module: demux_chan_fifo (WIDTH, CNT_W).
  - Contains the 2-entry FIFO, valid/ready pop logic and the delivered-beat counter.
  - Instantiated twice.
  - Top level holds only the sel steering and in_ready selection.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid0/1=0, data_out0/1=0, count0/1=0.
- Basic steering: out_ready0/1=1. Send data_in=15,sel=0, then data_in=5,sel=1 on consecutive cycles -> data_out0=15 valid one cycle later, then data_out1=5 valid the next cycle; count0=1, count1=1.
- Backpressure and full: out_ready0=0. Send 3,4,9 all with sel=0 -> 3 and 4 accepted, in_ready=0 on 9. Raise out_ready0 -> channel 0 delivers 3,4,9 in order.
- Independent channels: channel 0 full and stalled, then send 7 with sel=1 -> accepted (in_ready=1); data_out1=7 next cycle; channel 0 contents unchanged.
- Push/pop same cycle: occupancy0=1 (head 10), out_ready0=1, push 11 to ch0 -> occupancy stays 1, head becomes 11, count0 +1.
- Wrap and reset mid-stream: CNT_W=4, deliver 17 beats on ch1 -> count1=1. Assert rst with ch0 holding 2 beats -> both FIFOs empty and both counts 0 on the next cycle.
